// File: rtl/vga_timing_pkg.sv
// Shared definitions for the raster timing generator: controller states,
// total-period helper and standard mode presets.
package vga_timing_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } vga_state_e;

    // One complete mode description: display, porches, sync widths, polarities
    typedef struct packed {
        int   hd, hf, hs, hb;
        int   vd, vf, vs, vb;
        logic hs_pol, vs_pol;
    } vga_geom_t;

    // Total period of a line or frame: display + front porch + sync + back porch
    function automatic int calc_total(input int d, input int f, input int s, input int b);
        return d + f + s + b;
    endfunction

    localparam vga_geom_t PRESET_640X480  = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
    localparam vga_geom_t PRESET_800X600  = '{800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1};
    localparam vga_geom_t PRESET_1280X720 = '{1280, 110, 40, 220, 720, 5, 5, 20, 1'b1, 1'b1};

endpackage

// File: rtl/vga_pix_div.sv
// Pixel clock divider: free-running 0..CLK_DIV-1 counter from reset with a
// registered one-clk pixel_tick when the count sits at its last value.
module vga_pix_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic pixel_tick
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             pixel_tick_q, pixel_tick_d;

    // Wrap the divider and flag the last count of each pixel period
    always_comb begin
        div_cnt_d    = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);
        pixel_tick_d = (div_cnt_q == DIV_LAST);
    end

    // Divider state; runs regardless of the raster controller
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q    <= '0;
            pixel_tick_q <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            pixel_tick_q <= pixel_tick_d;
        end
    end

    assign pixel_tick = pixel_tick_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator with clean frame-boundary start/stop.
// All outputs are registered and decoded from the next counter value so the
// coordinates, syncs, video_on and strobes always describe the same pixel.
// Optional build macro VGA_TIMING_FRAME_CNT_EN adds frame_cnt and underflow_err.
module vga_timing_gen #(
    parameter int   CNT_W   = 11,
    parameter int   CLK_DIV = 2,
    parameter int   HD      = 800,
    parameter int   HF      = 40,
    parameter int   HS      = 128,
    parameter int   HB      = 88,
    parameter int   VD      = 600,
    parameter int   VF      = 1,
    parameter int   VS      = 4,
    parameter int   VB      = 23,
    parameter logic HS_POL  = 1'b1,
    parameter logic VS_POL  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic             pixel_tick,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic             line_start,
    output logic             frame_start,
    output logic             running
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0]      frame_cnt,
    output logic             underflow_err
`endif
);
    import vga_timing_pkg::*;

    localparam int H_TOTAL = calc_total(HD, HF, HS, HB);
    localparam int V_TOTAL = calc_total(VD, VF, VS, VB);

    // Inclusive bounds keep every constant inside CNT_W even with zero porches
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_DISP_L = CNT_W'(HD - 1);
    localparam logic [CNT_W-1:0] H_SYNC_F = CNT_W'(HD + HF);
    localparam logic [CNT_W-1:0] H_SYNC_L = CNT_W'(HD + HF + HS - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_DISP_L = CNT_W'(VD - 1);
    localparam logic [CNT_W-1:0] V_SYNC_F = CNT_W'(VD + VF);
    localparam logic [CNT_W-1:0] V_SYNC_L = CNT_W'(VD + VF + VS - 1);

    if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_cnt_w
        $error("vga_timing_gen: CNT_W=%0d cannot hold H_TOTAL-1=%0d / V_TOTAL-1=%0d",
               CNT_W, H_TOTAL - 1, V_TOTAL - 1);
    end
    if (CLK_DIV < 1) begin : g_bad_clk_div
        $error("vga_timing_gen: CLK_DIV=%0d must be >= 1", CLK_DIV);
    end

    logic tick;

    vga_pix_div #(.CLK_DIV(CLK_DIV)) u_pix_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .pixel_tick (tick)
    );

    vga_state_e       state_q, state_d;
    logic [CNT_W-1:0] h_q, h_d, v_q, v_d, h_adv, v_adv;
    logic             h_wrap, v_wrap, active;
    logic             hsync_q, hsync_d, vsync_q, vsync_d, video_on_q, video_on_d;
    logic             line_start_q, line_start_d, frame_start_q, frame_start_d;
    logic             running_q, running_d;

    // Next state, next raster position and the outputs decoded from it;
    // everything holds between pixel ticks
    always_comb begin
        h_wrap = (h_q == H_LAST);
        v_wrap = (v_q == V_LAST);
        h_adv  = h_wrap ? '0 : h_q + CNT_W'(1);
        v_adv  = h_wrap ? (v_wrap ? '0 : v_q + CNT_W'(1)) : v_q;

        state_d       = state_q;
        h_d           = h_q;
        v_d           = v_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        video_on_d    = video_on_q;
        line_start_d  = line_start_q;
        frame_start_d = frame_start_q;
        running_d     = running_q;
        active        = 1'b0;

        if (tick) begin
            case (state_q)
                IDLE:     if (en) state_d = RUN;
                RUN:      if (!en) state_d = STOPPING;
                STOPPING: begin
                    if (en)                  state_d = RUN;
                    else if (h_wrap && v_wrap) state_d = IDLE;
                end
                default:  state_d = IDLE;
            endcase

            // Leaving IDLE shows pixel (0,0); the stop point wraps to 0 anyway
            h_d    = (state_q == IDLE) ? '0 : h_adv;
            v_d    = (state_q == IDLE) ? '0 : v_adv;
            active = (state_d != IDLE);

            hsync_d       = (active && h_d >= H_SYNC_F && h_d <= H_SYNC_L) ? HS_POL : ~HS_POL;
            vsync_d       = (active && v_d >= V_SYNC_F && v_d <= V_SYNC_L) ? VS_POL : ~VS_POL;
            video_on_d    = active && (h_d <= H_DISP_L) && (v_d <= V_DISP_L);
            line_start_d  = active && (h_d == '0);
            frame_start_d = active && (h_d == '0) && (v_d == '0);
            running_d     = active;
        end
    end

    // Controller state, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            h_q           <= '0;
            v_q           <= '0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            video_on_q    <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            running_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            h_q           <= h_d;
            v_q           <= v_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            running_q     <= running_d;
        end
    end

    assign pixel_tick  = tick;
    assign pixel_x     = h_q;
    assign pixel_y     = v_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign running     = running_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        underflow_q, underflow_d, drop_last_q, drop_last_d;

    // Frame counter, plus a sticky error when en drops and comes back
    // while the last line of a stopping frame is being scanned
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        underflow_d = underflow_q;
        drop_last_d = drop_last_q;
        if (tick) begin
            if (frame_start_d) frame_cnt_d = frame_cnt_q + 16'd1;
            if (v_q == V_LAST && state_q != IDLE) begin
                if (!en)                                   drop_last_d = 1'b1;
                else if (drop_last_q && state_q == STOPPING) underflow_d = 1'b1;
            end
            if (v_d != V_LAST) drop_last_d = 1'b0;
        end
    end

    // Frame counter and error flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
            underflow_q <= 1'b0;
            drop_last_q <= 1'b0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            underflow_q <= underflow_d;
            drop_last_q <= drop_last_d;
        end
    end

    assign frame_cnt     = frame_cnt_q;
    assign underflow_err = underflow_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a tiny 14x8 raster.
// u0: CLK_DIV=2, positive syncs.  u1: CLK_DIV=1, active-low hsync.
module tb_vga_timing_gen;

    localparam int HT = 14;
    localparam int VT = 8;
    localparam int FT = HT * VT;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en0 = 1'b0;
    logic en1 = 1'b0;

    logic        t0, hs0, vs0, vid0, ls0, fs0, run0;
    logic [10:0] x0, y0;
    logic        t1, hs1, vs1, vid1, ls1, fs1, run1;
    logic [10:0] x1, y1;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] fc0, fc1;
    logic        uf0, uf1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .CNT_W(11), .CLK_DIV(2), .HD(8), .HF(2), .HS(3), .HB(1),
        .VD(4), .VF(1), .VS(2), .VB(1), .HS_POL(1'b1), .VS_POL(1'b1)
    ) u0 (
        .clk(clk), .rst_n(rst_n), .en(en0), .pixel_tick(t0),
        .pixel_x(x0), .pixel_y(y0), .hsync(hs0), .vsync(vs0),
        .video_on(vid0), .line_start(ls0), .frame_start(fs0), .running(run0)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_cnt(fc0), .underflow_err(uf0)
`endif
    );

    vga_timing_gen #(
        .CNT_W(11), .CLK_DIV(1), .HD(8), .HF(2), .HS(3), .HB(1),
        .VD(4), .VF(1), .VS(2), .VB(1), .HS_POL(1'b0), .VS_POL(1'b1)
    ) u1 (
        .clk(clk), .rst_n(rst_n), .en(en1), .pixel_tick(t1),
        .pixel_x(x1), .pixel_y(y1), .hsync(hs1), .vsync(vs1),
        .video_on(vid1), .line_start(ls1), .frame_start(fs1), .running(run1)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_cnt(fc1), .underflow_err(uf1)
`endif
    );

    logic [27:0] obs0, obs1;
    assign obs0 = {x0, y0, hs0, vs0, vid0, ls0, fs0, run0};
    assign obs1 = {x1, y1, hs1, vs1, vid1, ls1, fs1, run1};

    // Expected output vector for raster pixel index n of a running frame
    function automatic logic [27:0] expv(input int n, input logic hs_on);
        int   x = n % HT;
        int   y = (n / HT) % VT;
        logic hs = (x >= 10 && x < 13) ? hs_on : ~hs_on;
        logic vs = (y >= 5 && y < 7);
        logic vd = (x < 8 && y < 4);
        logic ls = (x == 0);
        logic fs = (x == 0 && y == 0);
        return {11'(x), 11'(y), hs, vs, vd, ls, fs, 1'b1};
    endfunction

    // Expected output vector while idle or in reset
    function automatic logic [27:0] idlev(input logic hs_on);
        return {11'd0, 11'd0, ~hs_on, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance u0 by one pixel tick and land on the negedge after the update
    task automatic tick0();
        int k = 0;
        while (t0 !== 1'b1 && k < 8) begin
            @(negedge clk);
            k++;
        end
        if (k >= 8) chk("tick_timeout", 64'(k), 64'd0);
        @(negedge clk);
    endtask

    initial begin
        int  vid_cnt;
        time t_f0, t_l1, t_f1;

        // reset state
        repeat (3) @(negedge clk);
        chk("reset_vec_u0", obs0, idlev(1'b1));
        chk("reset_tick_u0", t0, 0);
        chk("reset_vec_u1", obs1, idlev(1'b0));

        // start: first tick is pixel (0,0) with both strobes
        en0   = 1'b1;
        rst_n = 1'b1;
        tick0();
        chk("first_pixel", obs0, expv(0, 1'b1));
        t_f0    = $time;
        vid_cnt = int'(vid0);
        for (int n = 1; n < FT; n++) begin
            tick0();
            chk($sformatf("frame1 n=%0d", n), obs0, expv(n, 1'b1));
            vid_cnt += int'(vid0);
            if (n == HT) t_l1 = $time;
        end
        chk("line_period_clk", 64'(t_l1 - t_f0), 64'd280);
        chk("video_on_count", 64'(vid_cnt), 64'd32);
        tick0();
        chk("frame2_start", obs0, expv(0, 1'b1));
        t_f1 = $time;
        chk("frame_period_clk", 64'(t_f1 - t_f0), 64'd2240);

        // drop en at (3,2): frame completes, then idle
        for (int n = 1; n < FT; n++) begin
            tick0();
            chk($sformatf("stop_frame n=%0d", n), obs0, expv(n, 1'b1));
            if (n == 2 * HT + 3) en0 = 1'b0;
        end
        for (int i = 0; i < 6; i++) begin
            tick0();
            chk($sformatf("idle_after_stop i=%0d", i), obs0, idlev(1'b1));
        end
`ifdef VGA_TIMING_FRAME_CNT_EN
        chk("frame_cnt_hold", fc0, 2);
`endif

        // restart; glitch en between ticks; stop then resume at y=6
        en0 = 1'b1;
        tick0();
        chk("restart_pixel", obs0, expv(0, 1'b1));
        for (int n = 1; n < FT; n++) begin
            tick0();
            chk($sformatf("resume_frame n=%0d", n), obs0, expv(n, 1'b1));
            if (n == 5) begin
                en0 = 1'b0;
                @(posedge clk);
                #1 en0 = 1'b1;
                @(negedge clk);
            end
            if (n == 30) en0 = 1'b0;
            if (n == 6 * HT + 2) en0 = 1'b1;
        end
`ifdef VGA_TIMING_FRAME_CNT_EN
        chk("frame_cnt_three", fc0, 3);
`endif
        tick0();
        chk("resume_next_frame", obs0, expv(0, 1'b1));
        tick0();
        chk("resume_next_pixel", obs0, expv(1, 1'b1));
`ifdef VGA_TIMING_FRAME_CNT_EN
        chk("frame_cnt_four", fc0, 4);
`endif

        // CLK_DIV=1, active-low hsync: tick every clk
        en1 = 1'b1;
        @(negedge clk);
        chk("div1_first_pixel", obs1, expv(0, 1'b0));
        chk("div1_tick_high", t1, 1);
        for (int n = 1; n <= 11; n++) begin
            @(negedge clk);
            chk($sformatf("div1 n=%0d", n), obs1, expv(n, 1'b0));
            chk($sformatf("div1_tick n=%0d", n), t1, 1);
        end

        // asynchronous reset mid-line, away from any clock edge
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_u1", obs1, idlev(1'b0));
        chk("async_reset_tick_u1", t1, 0);
        chk("async_reset_u0", obs0, idlev(1'b1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
